// File: rtl/q_pkg.sv
// -----------------------------------------------------------------------------
// q_pkg
// Shared definitions for the multi-channel queue pointer controller.
//   ch_w()   : width of a channel index, never below 1 bit
//   addr_w() : entry-index width for an N-deep channel
//   cnt_w()  : pointer/occupancy width (entry index plus one wrap bit)
//   ch_req_t : per-channel decoded request bundle (push/pop/flush)
// -----------------------------------------------------------------------------
package q_pkg;

  function automatic int ch_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  typedef struct packed {
    logic push;
    logic pop;
    logic flush;
  } ch_req_t;

endpackage

// File: rtl/queue_cntrl_mc_ch.sv
// -----------------------------------------------------------------------------
// queue_cntrl_mc_ch
// Pointer pair, status flags and sticky error bits for one circular FIFO.
// Both pointers carry one wrap bit above the entry index, so occupancy is a
// plain modulo subtraction and full/empty are told apart by the wrap bit.
//
// Optional feature macro: Q_QUEUE_CNTRL_MC_ERR_EN
//   defined   : push to full / pop from empty is refused and flagged
//   undefined : requests pass unconditionally, error outputs tied low
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   i_push/i_pop/i_flush  requests already decoded for this channel
//   o_push_ok/o_pop_ok  request accepted this cycle (drives RAM strobes)
//   o_wr_idx/o_rd_idx   entry index of the current write/read pointer
//   o_full/o_empty/o_afull/o_cnt  status from registered pointers
//   o_ovf_err/o_unf_err sticky error flags
// -----------------------------------------------------------------------------
module queue_cntrl_mc_ch
  import q_pkg::*;
#(
  parameter int N         = 8,
  parameter int AF_THRESH = N - 2,
  localparam int ADDR_W   = addr_w(N),
  localparam int CNT_W    = cnt_w(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_push_ok,
  output logic              o_pop_ok,
  output logic [ADDR_W-1:0] o_wr_idx,
  output logic [ADDR_W-1:0] o_rd_idx,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_afull,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_ovf_err,
  output logic              o_unf_err
);

  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;

  assign o_empty  = (wr_ptr_q == rd_ptr_q);
  assign o_full   = (wr_ptr_q[CNT_W-1] != rd_ptr_q[CNT_W-1]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign o_cnt    = wr_ptr_q - rd_ptr_q;
  assign o_afull  = (o_cnt >= AF_LVL);
  assign o_wr_idx = wr_ptr_q[ADDR_W-1:0];
  assign o_rd_idx = rd_ptr_q[ADDR_W-1:0];

`ifdef Q_QUEUE_CNTRL_MC_ERR_EN
  // Legality looks only at registered state: a same-cycle pop does not make
  // room for a push, and a same-cycle push does not feed a pop.
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  assign o_push_ok = i_push && !i_flush && !o_full;
  assign o_pop_ok  = i_pop  && !i_flush && !o_empty;
  assign ovf_d     = ovf_q || (i_push && !i_flush && o_full);
  assign unf_d     = unf_q || (i_pop  && !i_flush && o_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign o_ovf_err = ovf_q;
  assign o_unf_err = unf_q;
`else
  // Caller guarantees legality; an illegal op simply walks the pointer.
  assign o_push_ok = i_push && !i_flush;
  assign o_pop_ok  = i_pop  && !i_flush;
  assign o_ovf_err = 1'b0;
  assign o_unf_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (o_push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (o_pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/queue_cntrl_mc.sv
// -----------------------------------------------------------------------------
// queue_cntrl_mc
// Multi-channel queue pointer controller. CH circular FIFOs of N entries each
// are statically partitioned in one shared RAM; the RAM address is
// {channel, entry index}. One push and one pop per cycle, each tagged with a
// channel, plus a per-channel flush.
//
// Optional feature macro: Q_QUEUE_CNTRL_MC_ERR_EN (overflow/underflow
// protection with sticky error flags; see queue_cntrl_mc_ch).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_push, i_push_ch        push request and its channel
//   i_pop,  i_pop_ch         pop request and its channel
//   i_flush, i_flush_ch      flush request and its channel
//   o_wr_en, o_wr_addr       RAM write strobe/address (combinational)
//   o_rd_en, o_rd_addr       RAM read strobe/address (combinational)
//   o_full/o_empty/o_afull   per-channel status, one bit per channel
//   o_cnt                    per-channel occupancy, channel c at [c*CNT_W +: CNT_W]
//   o_ovf_err/o_unf_err      per-channel sticky error flags
// -----------------------------------------------------------------------------
module queue_cntrl_mc
  import q_pkg::*;
#(
  parameter int CH        = 4,
  parameter int N         = 8,
  parameter int AF_THRESH = N - 2,
  localparam int CH_W     = ch_w(CH),
  localparam int ADDR_W   = addr_w(N),
  localparam int CNT_W    = cnt_w(N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [CH_W-1:0]        i_push_ch,
  input  logic                   i_pop,
  input  logic [CH_W-1:0]        i_pop_ch,
  input  logic                   i_flush,
  input  logic [CH_W-1:0]        i_flush_ch,
  output logic                   o_wr_en,
  output logic [CH_W+ADDR_W-1:0] o_wr_addr,
  output logic                   o_rd_en,
  output logic [CH_W+ADDR_W-1:0] o_rd_addr,
  output logic [CH-1:0]          o_full,
  output logic [CH-1:0]          o_empty,
  output logic [CH-1:0]          o_afull,
  output logic [CH*CNT_W-1:0]    o_cnt,
  output logic [CH-1:0]          o_ovf_err,
  output logic [CH-1:0]          o_unf_err
);

  ch_req_t [CH-1:0]  req;
  logic    [CH-1:0]  push_ok;
  logic    [CH-1:0]  pop_ok;
  logic [ADDR_W-1:0] wr_idx [CH];
  logic [ADDR_W-1:0] rd_idx [CH];
  logic [ADDR_W-1:0] wr_lo;
  logic [ADDR_W-1:0] rd_lo;

  // Channel decode. Indices >= CH match no channel and are dropped. Requests
  // are masked during reset so the RAM sees no strobe while state clears.
  always_comb begin
    req   = '0;
    wr_lo = '0;
    rd_lo = '0;
    for (int c = 0; c < CH; c++) begin
      req[c].push  = i_push  && !rst && (i_push_ch  == CH_W'(c));
      req[c].pop   = i_pop   && !rst && (i_pop_ch   == CH_W'(c));
      req[c].flush = i_flush && !rst && (i_flush_ch == CH_W'(c));
      if (i_push_ch == CH_W'(c)) wr_lo = wr_idx[c];
      if (i_pop_ch  == CH_W'(c)) rd_lo = rd_idx[c];
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    queue_cntrl_mc_ch #(
      .N         (N),
      .AF_THRESH (AF_THRESH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_push    (req[c].push),
      .i_pop     (req[c].pop),
      .i_flush   (req[c].flush),
      .o_push_ok (push_ok[c]),
      .o_pop_ok  (pop_ok[c]),
      .o_wr_idx  (wr_idx[c]),
      .o_rd_idx  (rd_idx[c]),
      .o_full    (o_full[c]),
      .o_empty   (o_empty[c]),
      .o_afull   (o_afull[c]),
      .o_cnt     (o_cnt[c*CNT_W +: CNT_W]),
      .o_ovf_err (o_ovf_err[c]),
      .o_unf_err (o_unf_err[c])
    );
  end

  // At most one channel can accept per direction, so OR-reducing is a select.
  assign o_wr_en   = |push_ok;
  assign o_rd_en   = |pop_ok;
  assign o_wr_addr = {i_push_ch, wr_lo};
  assign o_rd_addr = {i_pop_ch, rd_lo};

endmodule

// File: tb/tb_queue_cntrl_mc.sv
// -----------------------------------------------------------------------------
// tb_queue_cntrl_mc
// Directed, table-driven bench for queue_cntrl_mc (CH=4, N=8, AF_THRESH=6).
// Each record holds one cycle of requests and the outputs expected before the
// next rising edge. Expectations follow whichever build of
// Q_QUEUE_CNTRL_MC_ERR_EN is compiled.
// -----------------------------------------------------------------------------
module tb_queue_cntrl_mc;

`ifdef Q_QUEUE_CNTRL_MC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_push, i_pop, i_flush;
  logic [1:0]  i_push_ch, i_pop_ch, i_flush_ch;
  logic        o_wr_en, o_rd_en;
  logic [4:0]  o_wr_addr, o_rd_addr;
  logic [3:0]  o_full, o_empty, o_afull, o_ovf_err, o_unf_err;
  logic [15:0] o_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  queue_cntrl_mc #(.CH(4), .N(8), .AF_THRESH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_push     (i_push),
    .i_push_ch  (i_push_ch),
    .i_pop      (i_pop),
    .i_pop_ch   (i_pop_ch),
    .i_flush    (i_flush),
    .i_flush_ch (i_flush_ch),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_afull    (o_afull),
    .o_cnt      (o_cnt),
    .o_ovf_err  (o_ovf_err),
    .o_unf_err  (o_unf_err)
  );

  typedef struct {
    logic        push;
    logic [1:0]  pch;
    logic        pop;
    logic [1:0]  rch;
    logic        fl;
    logic [1:0]  fch;
    logic        we;
    logic [4:0]  wa;
    logic        re;
    logic [4:0]  ra;
    logic [3:0]  empty;
    logic [3:0]  full;
    logic [3:0]  afull;
    logic [15:0] cnt;
    logic [3:0]  ovf;
    logic [3:0]  unf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic v(input logic push, input logic [1:0] pch, input logic pop, input logic [1:0] rch,
                   input logic fl, input logic [1:0] fch,
                   input logic we, input logic [4:0] wa, input logic re, input logic [4:0] ra,
                   input logic [3:0] empty, input logic [3:0] full, input logic [3:0] afull,
                   input logic [15:0] cnt, input logic [3:0] ovf, input logic [3:0] unf);
    vec_t r;
    r = '{push, pch, pop, rch, fl, fch, we, wa, re, ra, empty, full, afull, cnt, ovf, unf};
    vecs.push_back(r);
  endtask

  task automatic idle_inputs();
    i_push = 1'b0; i_push_ch = 2'd0;
    i_pop = 1'b0; i_pop_ch = 2'd0;
    i_flush = 1'b0; i_flush_ch = 2'd0;
  endtask

  initial begin
    logic [3:0] ov, un;
    logic       e3;
    logic [3:0] c3;

    // ---------------- table construction ----------------
    ov = 4'h0;
    un = 4'h0;
    // idle after reset
    v(0,0,0,0,0,0, 0,0,0,0, 4'hF,4'h0,4'h0,16'h0000, ov,un);
    // fill ch2; afull from 6 entries, full at 8
    for (int k = 0; k < 8; k++)
      v(1,2,0,0,0,0, 1,5'(16+k),0,0, (k == 0) ? 4'hF : 4'hB, 4'h0,
        (k >= 6) ? 4'h4 : 4'h0, 16'(k*256), ov,un);
    // 9th push to full ch2
    v(1,2,0,0,0,0, !ERR_EN,5'h10,0,0, 4'hB,4'h4,4'h4,16'h0800, ov,un);
    // flush ch2 with push ch2: push suppressed
    ov = ERR_EN ? 4'h4 : 4'h0;
    v(1,2,0,0,1,2, 0,5'h10,0,0, 4'hB, ERR_EN ? 4'h4 : 4'h0, 4'h4,
      ERR_EN ? 16'h0800 : 16'h0900, ov,un);
    v(0,0,0,0,0,0, 0,0,0,0, 4'hF,4'h0,4'h0,16'h0000, ov,un);
    // ch1 lap 1 fill
    for (int k = 0; k < 8; k++)
      v(1,1,0,0,0,0, 1,5'(8+k),0,0, (k == 0) ? 4'hF : 4'hD, 4'h0,
        (k >= 6) ? 4'h2 : 4'h0, 16'(k*16), ov,un);
    // ch1 lap 1 drain
    for (int j = 0; j < 8; j++)
      v(0,0,1,1,0,0, 0,0,1,5'(8+j), 4'hD, (j == 0) ? 4'h2 : 4'h0,
        ((8-j) >= 6) ? 4'h2 : 4'h0, 16'((8-j)*16), ov,un);
    // ch1 lap 2: addresses restart at entry 0
    v(1,1,0,0,0,0, 1,5'h08,0,0, 4'hF,4'h0,4'h0,16'h0000, ov,un);
    v(1,1,0,0,0,0, 1,5'h09,0,0, 4'hD,4'h0,4'h0,16'h0010, ov,un);
    v(0,0,1,1,0,0, 0,0,1,5'h08, 4'hD,4'h0,4'h0,16'h0020, ov,un);
    v(0,0,1,1,0,0, 0,0,1,5'h09, 4'hD,4'h0,4'h0,16'h0010, ov,un);
    // ch0 to 3 entries
    v(1,0,0,0,0,0, 1,5'h00,0,0, 4'hF,4'h0,4'h0,16'h0000, ov,un);
    v(1,0,0,0,0,0, 1,5'h01,0,0, 4'hE,4'h0,4'h0,16'h0001, ov,un);
    v(1,0,0,0,0,0, 1,5'h02,0,0, 4'hE,4'h0,4'h0,16'h0002, ov,un);
    // ch0 simultaneous push+pop: count holds at 3
    for (int k = 0; k < 5; k++)
      v(1,0,1,0,0,0, 1,5'(3+k),1,5'(k), 4'hE,4'h0,4'h0,16'h0003, ov,un);
    // ch3 empty, push+pop same cycle: pop is illegal (no bypass)
    v(1,3,1,3,0,0, 1,5'h18,!ERR_EN,5'h18, 4'hE,4'h0,4'h0,16'h0003, ov,un);
    un = ERR_EN ? 4'h8 : 4'h0;
    e3 = !ERR_EN;
    c3 = ERR_EN ? 4'h1 : 4'h0;
    // ch2 to 5 entries
    for (int k = 0; k < 5; k++)
      v(1,2,0,0,0,0, 1,5'(16+k),0,0, {e3, 1'(k == 0), 1'b1, 1'b0}, 4'h0,4'h0,
        {c3, 4'(k), 4'h0, 4'h3}, ov,un);
    // flush ch2 + push ch2 (suppressed) + pop ch0 (unaffected)
    v(1,2,1,0,1,2, 0,5'h15,1,5'h05, {e3,1'b0,1'b1,1'b0}, 4'h0,4'h0,
      {c3,4'h5,4'h0,4'h3}, ov,un);
    // flush ch1 while pushing ch2: no interaction
    v(1,2,0,0,1,1, 1,5'h10,0,0, {e3,1'b1,1'b1,1'b0}, 4'h0,4'h0,
      {c3,4'h0,4'h0,4'h2}, ov,un);
    // pop on empty ch1
    v(0,0,1,1,0,0, 0,0,!ERR_EN,5'h08, {e3,1'b0,1'b1,1'b0}, 4'h0,4'h0,
      {c3,4'h1,4'h0,4'h2}, ov,un);
    un = ERR_EN ? 4'hA : 4'h0;
    v(0,0,0,0,0,0, 0,0,0,0, {e3,1'b0,ERR_EN,1'b0}, 4'h0, ERR_EN ? 4'h0 : 4'h2,
      {c3,4'h1, ERR_EN ? 4'h0 : 4'hF, 4'h2}, ov,un);

    // ---------------- reset with requests pending ----------------
    rst = 1'b1;
    idle_inputs();
    i_push = 1'b1;
    i_pop  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_dominates wr_en", 32'(o_wr_en), 32'(0));
    check("rst_dominates rd_en", 32'(o_rd_en), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    // ---------------- table application ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      i_push = vecs[i].push; i_push_ch = vecs[i].pch;
      i_pop = vecs[i].pop; i_pop_ch = vecs[i].rch;
      i_flush = vecs[i].fl; i_flush_ch = vecs[i].fch;
      #1;
      check($sformatf("v%0d wr_en", i), 32'(o_wr_en), 32'(vecs[i].we));
      check($sformatf("v%0d rd_en", i), 32'(o_rd_en), 32'(vecs[i].re));
      if (vecs[i].we) check($sformatf("v%0d wr_addr", i), 32'(o_wr_addr), 32'(vecs[i].wa));
      if (vecs[i].re) check($sformatf("v%0d rd_addr", i), 32'(o_rd_addr), 32'(vecs[i].ra));
      check($sformatf("v%0d empty", i), 32'(o_empty), 32'(vecs[i].empty));
      check($sformatf("v%0d full", i), 32'(o_full), 32'(vecs[i].full));
      check($sformatf("v%0d afull", i), 32'(o_afull), 32'(vecs[i].afull));
      check($sformatf("v%0d cnt", i), 32'(o_cnt), 32'(vecs[i].cnt));
      check($sformatf("v%0d ovf_err", i), 32'(o_ovf_err), 32'(vecs[i].ovf));
      check($sformatf("v%0d unf_err", i), 32'(o_unf_err), 32'(vecs[i].unf));
    end

    // ---------------- out-of-range channel is ignored ----------------
    // Only 4 channels with a 2-bit index, so every code is valid; instead
    // check a mid-run reset clears pointers and sticky flags together.
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    i_push = 1'b1; i_push_ch = 2'd2;
    #1;
    check("mid_rst wr_en", 32'(o_wr_en), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    check("post_rst empty", 32'(o_empty), 32'(4'hF));
    check("post_rst full", 32'(o_full), 32'(0));
    check("post_rst afull", 32'(o_afull), 32'(0));
    check("post_rst cnt", 32'(o_cnt), 32'(0));
    check("post_rst ovf_err", 32'(o_ovf_err), 32'(0));
    check("post_rst unf_err", 32'(o_unf_err), 32'(0));

    // first push after reset lands on entry 0 of its channel
    @(negedge clk);
    i_push = 1'b1; i_push_ch = 2'd3;
    #1;
    check("post_rst wr_addr", 32'(o_wr_addr), 32'(5'h18));
    @(negedge clk);
    idle_inputs();
    #1;
    check("post_rst cnt3", 32'(o_cnt), 32'(16'h1000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
